// File: rtl/yp_fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
// Holds the two-state FSM encoding and the grant-id width helper.
package yp_fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MAX_BURST  = 8;

    // A single requester still needs a one-bit id so the port never collapses to zero width.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/yp_rr_picker.sv
// Combinational round-robin picker: first asserted request strictly after
// the previous winner, wrapping around the requester range.
module yp_rr_picker
    import yp_fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int GW      = gid_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_last_grant,
    output logic [GW-1:0]      o_pick,
    output logic               o_any
);

    logic w_found;
    int   w_idx;

    // Scan from last_grant+1 so the previous winner is considered last.
    always_comb begin
        o_pick  = '0;
        o_any   = |i_req;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last_grant) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx[GW-1:0]]) begin
                o_pick  = w_idx[GW-1:0];
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yp_fifo_wr_arb.sv
// Packet-aware round-robin arbiter that merges several beat streams into
// one sync FIFO write port, holding each grant until last or MAX_BURST.
module yp_fifo_wr_arb
    import yp_fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int MAX_BURST  = DEF_MAX_BURST,
    localparam int GW         = gid_width(NUM_REQ)
) (
    input  logic                               i_clk,
    input  logic                               i_rstn,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]                 i_req_last,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    output logic                               o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]              o_fifo_data,
    input  logic                               i_fifo_full,
    output logic [GW-1:0]                      o_grant_id,
    output logic                               o_busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_e    r_state, w_state_nxt;
    logic [GW-1:0] r_grant_id, w_grant_id_nxt;
    logic [GW-1:0] r_last_grant, w_last_grant_nxt;
    logic [CW-1:0] r_beat_cnt, w_beat_cnt_nxt, w_cnt_inc;
    logic [GW-1:0] w_pick;
    logic          w_any;
    logic          w_xfer;

    yp_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req        (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick),
        .o_any        (w_any)
    );

    // last_grant resets to the top index so requester 0 wins the first arbitration.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_id_nxt   = r_grant_id;
        w_last_grant_nxt = r_last_grant;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_cnt_inc        = r_beat_cnt + CW'(1);
        w_xfer           = 1'b0;
        o_req_ready      = '0;
        o_fifo_wr_en     = 1'b0;
        o_fifo_data      = '0;
        o_busy           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_id_nxt = w_pick;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // A valid drop simply stalls the grant; only last or a full burst releases it.
                o_busy                  = 1'b1;
                o_req_ready[r_grant_id] = !i_fifo_full;
                w_xfer                  = i_req_valid[r_grant_id] & !i_fifo_full;
                o_fifo_wr_en            = w_xfer;
                o_fifo_data             = i_req_data[r_grant_id];
                if (w_xfer) begin
                    w_beat_cnt_nxt = w_cnt_inc;
                    if (i_req_last[r_grant_id] || (w_cnt_inc == CW'(MAX_BURST))) begin
                        w_state_nxt      = ST_IDLE;
                        w_last_grant_nxt = r_grant_id;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_yp_fifo_wr_arb.sv
// Self-checking bench for yp_fifo_wr_arb: directed scenarios plus a random
// phase, all compared against a packet-queue reference model.
module tb_yp_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 8;
    localparam int QD = 64;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [N-1:0]         reqValid;
    logic [N-1:0][DW-1:0] reqData;
    logic [N-1:0]         reqLast;
    logic [N-1:0]         reqReady;
    logic                 wrEn;
    logic [DW-1:0]        fifoData;
    logic                 fifoFull;
    logic [1:0]           grantId;
    logic                 busy;

    always #5 clk = ~clk;

    yp_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req_valid  (reqValid),
        .i_req_data   (reqData),
        .i_req_last   (reqLast),
        .o_req_ready  (reqReady),
        .o_fifo_wr_en (wrEn),
        .o_fifo_data  (fifoData),
        .i_fifo_full  (fifoFull),
        .o_grant_id   (grantId),
        .o_busy       (busy)
    );

    // Per-requester pending beats, as ring buffers.
    logic [DW-1:0] qData [N][QD];
    bit            qLast [N][QD];
    int            qHead [N];
    int            qTail [N];

    // Reference model: who owns the FIFO, beats sent, previous winner.
    bit mBusy;
    int mOwner, mCnt, mLastG;

    // Observations taken from the DUT outputs.
    int dGrant[$];
    int dBurst[$];
    int curBurst, dutWrites, stallObs;
    bit prevBusy;

    int nChecks, nErrors, totalPushed, stepNo;
    int maskReq, maskFrom, maskTo, fullFrom, fullTo;
    bit randMode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gAt(input int i);
        return (i < dGrant.size()) ? dGrant[i] : -1;
    endfunction

    function automatic int bAt(input int i);
        return (i < dBurst.size()) ? dBurst[i] : -1;
    endfunction

    function automatic bit allEmpty();
        bit e = 1'b1;
        for (int r = 0; r < N; r++) if (qHead[r] != qTail[r]) e = 1'b0;
        return e;
    endfunction

    task automatic pushBeat(input int r, input logic [DW-1:0] d, input bit last);
        qData[r][qTail[r] % QD] = d;
        qLast[r][qTail[r] % QD] = last;
        qTail[r]++;
        totalPushed++;
    endtask

    task automatic pushPkt(input int r, input int len, input bit withLast);
        for (int i = 0; i < len; i++) pushBeat(r, DW'($urandom), withLast && (i == len - 1));
    endtask

    task automatic applyStimulus();
        for (int r = 0; r < N; r++) begin
            reqValid[r] = (qHead[r] != qTail[r])
                          && !(r == maskReq && stepNo >= maskFrom && stepNo < maskTo)
                          && (!randMode || ($urandom_range(0, 99) < 85));
            reqData[r]  = qData[r][qHead[r] % QD];
            reqLast[r]  = qLast[r][qHead[r] % QD];
        end
        fifoFull = randMode ? ($urandom_range(0, 99) < 15) : (stepNo >= fullFrom && stepNo < fullTo);
    endtask

    // One clock: drive, check at the falling edge, then advance the model.
    task automatic step();
        logic [N-1:0] expReady;
        bit           expWr, lastBeat, found;
        int           r;
        applyStimulus();
        @(negedge clk);
        if (busy && !prevBusy) begin
            dGrant.push_back(int'(grantId));
            curBurst = 0;
        end
        if (wrEn) begin
            dutWrites++;
            curBurst++;
        end
        if (!busy && prevBusy) dBurst.push_back(curBurst);
        if (fifoFull && busy && !wrEn && reqReady == '0) stallObs++;
        prevBusy = busy;

        expReady = '0;
        expWr    = 1'b0;
        if (mBusy) begin
            if (!fifoFull) expReady = N'(1) << mOwner;
            expWr = reqValid[mOwner] && !fifoFull;
        end
        check("busy", 32'(busy), 32'(mBusy));
        check("wr_en", 32'(wrEn), 32'(expWr));
        check("ready", 32'(reqReady), 32'(expReady));
        if (mBusy) check("grant_id", 32'(grantId), 32'(mOwner));
        if (expWr) check("data", 32'(fifoData), 32'(qData[mOwner][qHead[mOwner] % QD]));

        if (mBusy) begin
            if (expWr) begin
                lastBeat = qLast[mOwner][qHead[mOwner] % QD];
                qHead[mOwner]++;
                mCnt++;
                if (lastBeat || mCnt == MB) begin
                    mBusy  = 1'b0;
                    mLastG = mOwner;
                end
            end
        end else if (reqValid != '0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                r = (mLastG + k) % N;
                if (!found && reqValid[r]) begin
                    mOwner = r;
                    found  = 1'b1;
                end
            end
            mBusy = 1'b1;
            mCnt  = 0;
        end
        @(posedge clk);
        #1;
        stepNo++;
    endtask

    // Asynchronous reset, checked before any clock edge can intervene.
    task automatic doReset();
        rstn = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_en", 32'(wrEn), 32'd0);
        check("rst_ready", 32'(reqReady), 32'd0);
        check("rst_grant_id", 32'(grantId), 32'd0);
        for (int r = 0; r < N; r++) begin
            qHead[r] = 0;
            qTail[r] = 0;
        end
        reqValid = '0; reqLast = '0; reqData = '0; fifoFull = 1'b0;
        mBusy = 1'b0; mOwner = 0; mCnt = 0; mLastG = N - 1;
        dGrant.delete(); dBurst.delete();
        curBurst = 0; dutWrites = 0; stallObs = 0; prevBusy = 1'b0;
        totalPushed = 0; stepNo = 0; randMode = 1'b0;
        maskReq = -1; maskFrom = 0; maskTo = 0; fullFrom = 0; fullTo = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic runIdle(input int maxSteps, input string tag);
        int n = 0;
        while (!(allEmpty() && !mBusy) && n < maxSteps) begin
            step();
            n++;
        end
        check(tag, 32'(n < maxSteps), 32'd1);
        step();
        step();
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        check(tag, 32'(obs), 32'(exp));
    endtask

    initial begin
        int n;
        int expOrd[5] = '{0, 1, 2, 3, 0};
        nChecks = 0; nErrors = 0;
        rstn = 1'b1; reqValid = '0; reqLast = '0; reqData = '0; fifoFull = 1'b0;
        #3;

        $display("[TB] single requester, three-beat packet");
        doReset();
        pushBeat(1, 8'hA0, 1'b0);
        pushBeat(1, 8'hA1, 1'b0);
        pushBeat(1, 8'hA2, 1'b1);
        runIdle(50, "t1_drain");
        checkOutput("t1_grants", dGrant.size(), 1);
        checkOutput("t1_owner", gAt(0), 1);
        checkOutput("t1_beats", bAt(0), 3);
        checkOutput("t1_writes", dutWrites, 3);

        $display("[TB] all requesters, one-beat packets");
        doReset();
        pushPkt(0, 1, 1'b1);
        pushPkt(0, 1, 1'b1);
        for (int r = 1; r < N; r++) pushPkt(r, 1, 1'b1);
        runIdle(50, "t2_drain");
        checkOutput("t2_grants", dGrant.size(), 5);
        for (int i = 0; i < 5; i++) checkOutput($sformatf("t2_order%0d", i), gAt(i), expOrd[i]);

        $display("[TB] twenty-beat stream without last");
        doReset();
        pushPkt(2, 20, 1'b0);
        n = 0;
        while (qHead[2] != qTail[2] && n < 80) begin
            step();
            n++;
        end
        checkOutput("t3_drain", int'(n < 80), 1);
        step();
        checkOutput("t3_busy", int'(busy), 1);
        checkOutput("t3_writes", dutWrites, 20);
        checkOutput("t3_bursts", dBurst.size(), 2);
        checkOutput("t3_burst0", bAt(0), 8);
        checkOutput("t3_burst1", bAt(1), 8);
        checkOutput("t3_grants", dGrant.size(), 3);
        checkOutput("t3_owner2", gAt(2), 2);

        $display("[TB] fifo full for five cycles mid-burst");
        doReset();
        pushPkt(0, 10, 1'b1);
        fullFrom = 3;
        fullTo   = 8;
        runIdle(60, "t4_drain");
        checkOutput("t4_stalls", stallObs, 5);
        checkOutput("t4_writes", dutWrites, 10);
        checkOutput("t4_burst0", bAt(0), 8);
        checkOutput("t4_burst1", bAt(1), 2);

        $display("[TB] granted requester drops valid mid-packet");
        doReset();
        pushPkt(3, 6, 1'b1);
        maskReq  = 3;
        maskFrom = 3;
        maskTo   = 6;
        step();
        pushPkt(0, 2, 1'b1);
        runIdle(60, "t5_drain");
        checkOutput("t5_grants", dGrant.size(), 2);
        checkOutput("t5_first", gAt(0), 3);
        checkOutput("t5_second", gAt(1), 0);
        checkOutput("t5_beats", bAt(0), 6);

        $display("[TB] reset in the middle of a grant");
        doReset();
        pushPkt(1, 6, 1'b1);
        step();
        step();
        step();
        checkOutput("t6_busy_before", int'(busy), 1);
        doReset();
        pushPkt(1, 3, 1'b1);
        pushPkt(0, 2, 1'b1);
        runIdle(60, "t6_drain");
        checkOutput("t6_first", gAt(0), 0);
        checkOutput("t6_second", gAt(1), 1);
        checkOutput("t6_writes", dutWrites, 5);

        $display("[TB] random traffic");
        doReset();
        randMode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            for (int r = 0; r < N; r++)
                if ((qTail[r] - qHead[r]) <= QD - 20 && $urandom_range(0, 99) < 10)
                    pushPkt(r, $urandom_range(1, 20), 1'b1);
            step();
        end
        runIdle(4000, "rand_drain");
        checkOutput("rand_writes", dutWrites, totalPushed);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/yp_fifo_wr_arb.md
YP_FIFO_WR_ARB -- requirements
Module: yp_fifo_wr_arb

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 4: number of write requesters (2..8).
- DATA_WIDTH, 8: beat width; equals the sync FIFO data width.
- MAX_BURST, 8: maximum beats per grant (1..16).
REQ-002 Ports SHALL be, one per line:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_data  in  NUM_REQ x DATA_WIDTH  per-requester beat data.
- i_req_last  in  NUM_REQ  per-requester last beat of packet.
- o_req_ready  out  NUM_REQ  per-requester beat accepted.
- o_fifo_wr_en  out  1  FIFO write enable.
- o_fifo_data  out  DATA_WIDTH  FIFO write data.
- i_fifo_full  in  1  FIFO full flag.
- o_grant_id  out  clog2(NUM_REQ)  current grant owner.
- o_busy  out  1  grant active.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-004 In IDLE, when any i_req_valid is high, the block SHALL round-robin select the first valid index after last_grant (wrapping at NUM_REQ), register it into o_grant_id, and enter GRANT next cycle.
REQ-005 In IDLE, all o_req_ready bits and o_fifo_wr_en SHALL be 0.
REQ-006 In GRANT, o_req_ready[o_grant_id] SHALL equal !i_fifo_full combinationally, and all other ready bits SHALL be 0.
REQ-007 In GRANT, o_fifo_wr_en SHALL equal i_req_valid[o_grant_id] & !i_fifo_full, and o_fifo_data SHALL equal i_req_data[o_grant_id], with zero-cycle latency.
REQ-008 A beat SHALL transfer on a cycle where valid & ready are both high; the beat counter SHALL increment by 1 per transfer and clear on entry to GRANT.
REQ-009 GRANT SHALL return to IDLE after a transfer where i_req_last is high or the beat count reaches MAX_BURST; last_grant SHALL update to o_grant_id on that exit.
REQ-010 Every grant SHALL be followed by one IDLE cycle (one-cycle bubble between grants).
REQ-011 A valid drop mid-packet SHALL NOT end the grant; GRANT SHALL hold until last or MAX_BURST.
REQ-012 When i_fifo_full is high, GRANT SHALL hold with no transfer, and the beat counter and state SHALL be unchanged.
REQ-013 Valids that assert while GRANT is active SHALL be considered only at the next IDLE.
REQ-014 o_busy SHALL be 1 exactly in GRANT.
REQ-015 A single persistent requester SHALL be re-granted after each bubble; no requester SHALL wait more than NUM_REQ-1 grants.

Reset
REQ-016 On i_rstn low, the state SHALL be IDLE, o_grant_id 0, last_grant NUM_REQ-1 (so requester 0 wins first), beat counter 0, o_busy 0, and all ready/wr_en 0.
REQ-017 Reset mid-GRANT SHALL abandon the packet immediately; no further FIFO write SHALL occur until a fresh arbitration.

Structure
REQ-018 Package yp_fifo_arb_pkg SHALL hold the FSM state enum, the default parameter constants, and the grant-id width function.
REQ-019 Round-robin selection SHALL be a combinational sub-module yp_rr_picker (inputs: request vector, last_grant; outputs: pick index, any_valid).

Verification
REQ-020 Reset then single requester: req1 sends 3 beats A0,A1,A2 with last on A2 -> grant_id=1 on cycle 2, three consecutive wr_en with data A0..A2, then IDLE.
REQ-021 All 4 valid, each sending 1-beat packets -> grant order 0,1,2,3,0, with one IDLE cycle between grants.
REQ-022 MAX_BURST=8, req2 sends a 20-beat stream with no last -> grants of 8, 8, then 4 beats, each split by an IDLE bubble.
REQ-023 i_fifo_full high for 5 cycles mid-burst -> ready=0 and wr_en=0 for those 5 cycles, no beat lost or duplicated, burst resumes.
REQ-024 Granted requester drops valid for 3 cycles mid-packet while req0 is valid -> grant is held, req0 is never granted until last.
REQ-025 i_rstn pulses low mid-GRANT -> outputs zero asynchronously; after release, requester 0 (if valid) is granted first.
